// File: rtl/valid_stream_receiver_fifo_pkg.sv
// Shared helpers for the valid-stream receiver FIFO: pointer width and drop counter width.
package valid_stream_pkg;

  localparam int DROP_CNT_W = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/valid_stream_receiver_fifo_ptr.sv
// Circular-buffer pointer: index bits plus one wrap bit, advancing on inc.
module circular_buffer_ptr
  import valid_stream_pkg::*;
#(
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [ptr_w(depth)-1:0]  ptr
);

  localparam int PW = ptr_w(depth);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Wraps modulo 2*depth; the MSB toggles once per lap of the buffer.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/valid_stream_receiver_fifo.sv
// Receiver FIFO for a valid-only stream, re-presented on valid/ready; drops beats when full.
// Optional drop counter output enabled by VALID_STREAM_RECEIVER_DROP_CNT_EN.
module valid_stream_receiver_fifo
  import valid_stream_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [width-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [width-1:0]           out_data,
  output logic [$clog2(depth+1)-1:0] level,
  output logic                       overflow
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

  localparam int PW = ptr_w(depth);
  localparam int IW = $clog2(depth);
  localparam int LW = $clog2(depth + 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic             overflow_q;
  logic             overflow_d;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign pop   = ~empty & out_ready;
  // A slot freed by a same-cycle pop can be refilled immediately.
  assign push  = in_valid & (~full | pop);
  assign drop  = in_valid & full & ~pop;

  circular_buffer_ptr #(.depth(depth)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  circular_buffer_ptr #(.depth(depth)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr[IW-1:0]] = in_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr[IW-1:0]];
  assign level     = LW'(wr_ptr - rd_ptr);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_valid_stream_receiver_fifo.sv
// Self-checking bench for valid_stream_receiver_fifo against a queue-based occupancy model.
// Also covers drop_cnt when VALID_STREAM_RECEIVER_DROP_CNT_EN is defined.
module tb_valid_stream_receiver_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             overflow;
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  valid_stream_receiver_fifo #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] q[$];
  bit  m_ovf;
  int  m_drops;
  int  accepted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit rdy);
    bit full, pop, push, drop;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) chk("out_data", {24'b0, out_data}, {24'b0, q[0]});
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && rdy;
    push = iv && (!full || pop);
    drop = iv && full && !pop;
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) begin q.push_back(d); accepted++; end
    if (drop) begin m_ovf = 1'b1; if (m_drops < 65535) m_drops++; end
    chk("level", {{(32-LW){1'b0}}, level}, q.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
    chk("drop_cnt", {16'b0, drop_cnt}, m_drops);
`endif
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
`endif
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_ovf     = 1'b0;
    m_drops   = 0;
    accepted  = 0;
    #1;
    do_reset();

    // First beat after reset release, then mid-stream reset.
    step(1'b1, 8'h11, 1'b0);
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_data", {24'b0, out_data}, 32'h11);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b1);
    do_reset();

    // Fill, overflow, drain.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_level", {{(32-LW){1'b0}}, level}, DEPTH);
    chk("fill_overflow", {31'b0, overflow}, 32'd0);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", {31'b0, overflow}, 32'd1);
`ifdef VALID_STREAM_RECEIVER_DROP_CNT_EN
    chk("ovf_drop_cnt", {16'b0, drop_cnt}, 32'd1);
`endif
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_level", {{(32-LW){1'b0}}, level}, 32'd0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Full with simultaneous pop: the freed slot is reused.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    step(1'b1, 8'h5C, 1'b1);
    chk("fullpop_level", {{(32-LW){1'b0}}, level}, DEPTH);
    chk("fullpop_overflow", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("fullpop_empty", {31'b0, out_valid}, 32'd0);

    // Wrap-around: 40 accepted beats with ~70% ready.
    do_reset();
    accepted = 0;
    cyc = 0;
    while (accepted < 40 && cyc < 400) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("wrap_progress", {31'b0, accepted >= 40}, 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);

    // Random with repeated resets; heavy input pressure provokes drops.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 3 * DEPTH; c++)
        step($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 9) < 4);
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
